// File: rtl/video_pkg.sv
// ============================================================================
// Module   : video_pkg
// Brief    : Shared timing defaults, FSM encoding and overlay types for the
//            video overlay controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_pkg;

    localparam int c_H_ACTIVE = 1366;
    localparam int c_H_BLANK  = 50;
    localparam int c_V_ACTIVE = 768;
    localparam int c_V_BLANK  = 12;
    localparam int c_ADDR_W   = 14;
    localparam int c_CNT_W    = 11;
    localparam int c_BOUND_W  = 12;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [c_CNT_W-1:0] x;
        logic [c_CNT_W-1:0] y;
        logic [7:0]         w;
        logic [7:0]         h;
    } ovl_cfg_t;

    typedef struct packed {
        logic               de;
        logic               hsync;
        logic               vsync;
        logic [c_CNT_W-1:0] px;
        logic [c_CNT_W-1:0] py;
    } timing_t;

    localparam timing_t c_TIMING_IDLE = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1, px: '0, py: '0};

    // Window end is formed one bit wider so start+len can never wrap around.
    function automatic logic in_span(input logic [c_CNT_W-1:0] pos,
                                     input logic [c_CNT_W-1:0] start,
                                     input logic [7:0]         len);
        logic [c_BOUND_W-1:0] stop;
        stop = {1'b0, start} + {{(c_BOUND_W-8){1'b0}}, len};
        return (pos >= start) && ({1'b0, pos} < stop);
    endfunction

endpackage

`default_nettype wire

// File: rtl/video_raster_cnt.sv
// ============================================================================
// Module   : video_raster_cnt
// Brief    : Raster x/y counters plus a two-stage de/hsync/vsync/pixel pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_raster_cnt
    import video_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_BLANK  = c_H_BLANK,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_BLANK  = c_V_BLANK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_run,
    output logic [c_CNT_W-1:0] o_x,
    output logic [c_CNT_W-1:0] o_y,
    output logic               o_boundary,
    output logic               o_de,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic [c_CNT_W-1:0] o_pix_x,
    output logic [c_CNT_W-1:0] o_pix_y
);

    localparam logic [c_CNT_W-1:0] c_X_MAX  = c_CNT_W'(H_ACTIVE + H_BLANK - 1);
    localparam logic [c_CNT_W-1:0] c_Y_MAX  = c_CNT_W'(V_ACTIVE + V_BLANK - 1);
    localparam logic [c_CNT_W-1:0] c_HA     = c_CNT_W'(H_ACTIVE);
    localparam logic [c_CNT_W-1:0] c_VA     = c_CNT_W'(V_ACTIVE);
    localparam logic [c_CNT_W-1:0] c_HS_END = c_CNT_W'(H_ACTIVE + H_BLANK / 2);
    localparam logic [c_CNT_W-1:0] c_VS_END = c_CNT_W'(V_ACTIVE + V_BLANK / 2);

    logic [c_CNT_W-1:0] x_q, x_d;
    logic [c_CNT_W-1:0] y_q, y_d;
    timing_t            t1_q, t1_d;
    timing_t            t2_q, t2_d;
    logic               w_x_last;
    logic               w_y_last;

    assign w_x_last = (x_q == c_X_MAX);
    assign w_y_last = (y_q == c_Y_MAX);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!i_run) begin
            x_d = '0;
            y_d = '0;
        end else if (w_x_last) begin
            x_d = '0;
            y_d = w_y_last ? '0 : y_q + 1'b1;
        end else begin
            x_d = x_q + 1'b1;
        end
    end

    // Stage 1 decodes the counters; stage 2 realigns with the RAM read data.
    always_comb begin
        t1_d = c_TIMING_IDLE;
        if (i_run) begin
            t1_d.de    = (x_q < c_HA) && (y_q < c_VA);
            t1_d.hsync = !((x_q >= c_HA) && (x_q < c_HS_END));
            t1_d.vsync = !((y_q >= c_VA) && (y_q < c_VS_END));
            t1_d.px    = x_q;
            t1_d.py    = y_q;
        end
    end

    assign t2_d = t1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            t1_q <= c_TIMING_IDLE;
            t2_q <= c_TIMING_IDLE;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            t1_q <= t1_d;
            t2_q <= t2_d;
        end
    end

    assign o_x        = x_q;
    assign o_y        = y_q;
    assign o_boundary = i_run && w_x_last && w_y_last;
    assign o_de       = t2_q.de;
    assign o_hsync    = t2_q.hsync;
    assign o_vsync    = t2_q.vsync;
    assign o_pix_x    = t2_q.px;
    assign o_pix_y    = t2_q.py;

endmodule

`default_nettype wire

// File: rtl/video_overlay_ctrl.sv
// ============================================================================
// Module   : video_overlay_ctrl
// Brief    : Raster timing with a frame-synchronous overlay window that
//            schedules image-RAM reads and the pixel mux select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_overlay_ctrl
    import video_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_BLANK  = c_H_BLANK,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_BLANK  = c_V_BLANK,
    parameter int ADDR_W   = c_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [10:0]        cfg_x,
    input  logic [10:0]        cfg_y,
    input  logic [7:0]         cfg_w,
    input  logic [7:0]         cfg_h,
    output logic               ram_en,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               sel_image,
    output logic [10:0]        pix_x,
    output logic [10:0]        pix_y,
    output logic               frame_start
);

    localparam logic [c_CNT_W-1:0] c_HA = c_CNT_W'(H_ACTIVE);
    localparam logic [c_CNT_W-1:0] c_VA = c_CNT_W'(V_ACTIVE);

    state_t             state_q, state_d;
    ovl_cfg_t           act_q, act_d;
    ovl_cfg_t           shd_q, shd_d;
    logic               pend_q, pend_d;
    logic               ram_en_q, ram_en_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic               sel_image_q, sel_image_d;

    logic               w_run;
    logic               w_boundary;
    logic [c_CNT_W-1:0] w_x;
    logic [c_CNT_W-1:0] w_y;
    logic               w_cfg_fire;
    logic               w_in_win;

    assign w_run = (state_q != ST_OFF);

    video_raster_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .i_run      (w_run),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_boundary (w_boundary),
        .o_de       (de),
        .o_hsync    (hsync),
        .o_vsync    (vsync),
        .o_pix_x    (pix_x),
        .o_pix_y    (pix_y)
    );

    // Stopping is only ever decided at the frame boundary, so a frame always completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF:   if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = w_boundary ? ST_OFF : ST_DRAIN;
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (w_boundary) begin
                    state_d = ST_OFF;
                end
            end
            default:  state_d = ST_OFF;
        endcase
    end

    assign w_cfg_fire = cfg_valid && !pend_q;

    // A capture on the boundary cycle sets pending for the following boundary.
    always_comb begin
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        if (w_boundary && pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end
        if (w_cfg_fire) begin
            shd_d  = '{x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h};
            pend_d = 1'b1;
        end
    end

    assign w_in_win = w_run && (w_x < c_HA) && (w_y < c_VA) &&
                      in_span(w_x, act_q.x, act_q.w) && in_span(w_y, act_q.y, act_q.h);

    always_comb begin
        ram_en_d    = w_in_win;
        sel_image_d = ram_en_q;
        ram_addr_d  = ram_addr_q + {{(ADDR_W-1){1'b0}}, ram_en_q};
        if (w_boundary) begin
            ram_addr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OFF;
            act_q       <= '0;
            shd_q       <= '0;
            pend_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            sel_image_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            shd_q       <= shd_d;
            pend_q      <= pend_d;
            ram_en_q    <= ram_en_d;
            ram_addr_q  <= ram_addr_d;
            sel_image_q <= sel_image_d;
        end
    end

    assign cfg_ready   = !pend_q;
    assign ram_en      = ram_en_q;
    assign ram_addr    = ram_addr_q;
    assign sel_image   = sel_image_q;
    assign frame_start = w_boundary;

endmodule

`default_nettype wire

// File: tb/tb_video_overlay_ctrl.sv
// ============================================================================
// Module   : tb_video_overlay_ctrl
// Brief    : Self-checking bench for video_overlay_ctrl on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_overlay_ctrl;

    localparam int HA    = 20;
    localparam int HB    = 6;
    localparam int VA    = 12;
    localparam int VB    = 4;
    localparam int AW    = 6;
    localparam int HT    = HA + HB;
    localparam int VT    = VA + VB;
    localparam int TOTAL = HT * VT;
    localparam int SPAN  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [10:0]   cfg_x = '0;
    logic [10:0]   cfg_y = '0;
    logic [7:0]    cfg_w = '0;
    logic [7:0]    cfg_h = '0;
    logic          cfg_ready;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          sel_image;
    logic [10:0]   pix_x;
    logic [10:0]   pix_y;
    logic          frame_start;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    video_overlay_ctrl #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .V_BLANK  (VB),
        .ADDR_W   (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_x       (cfg_x),
        .cfg_y       (cfg_y),
        .cfg_w       (cfg_w),
        .cfg_h       (cfg_h),
        .ram_en      (ram_en),
        .ram_addr    (ram_addr),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .sel_image   (sel_image),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic s_rst, s_en, s_valid;
    int   s_cx, s_cy, s_cw, s_ch;
    always @(posedge clk) begin
        s_rst   <= rst;
        s_en    <= enable;
        s_valid <= cfg_valid;
        s_cx    <= int'(cfg_x);
        s_cy    <= int'(cfg_y);
        s_cw    <= int'(cfg_w);
        s_ch    <= int'(cfg_h);
    end

    // Reference model: frame position, config slots and short output history.
    initial begin : model_and_compare
        bit m_run, m_pend, m_ren, m_sel, bnd, hs, fs_e, de_e, hs_e, vs_e;
        int m_pos, m_addr, mx, my;
        int m_act[4];
        int m_shd[4];
        bit h1_run, h2_run;
        int h1_x, h1_y, h2_x, h2_y;
        forever begin
            @(negedge clk);
            mx = m_pos % HT;
            my = m_pos / HT;
            if (s_rst) begin
                m_run = 0; m_pos = 0; m_pend = 0; m_addr = 0; m_ren = 0; m_sel = 0;
                m_act = '{0, 0, 0, 0};
                m_shd = '{0, 0, 0, 0};
                h1_run = 0; h2_run = 0; h1_x = 0; h1_y = 0; h2_x = 0; h2_y = 0;
            end else begin
                bnd = m_run && (m_pos == TOTAL - 1);
                h2_run = h1_run; h2_x = h1_x; h2_y = h1_y;
                h1_run = m_run;  h1_x = mx;   h1_y = my;
                m_sel = m_ren;
                if (bnd) m_addr = 0;
                else if (m_ren) m_addr = (m_addr + 1) % SPAN;
                m_ren = m_run && mx < HA && my < VA &&
                        mx >= m_act[0] && mx < m_act[0] + m_act[2] &&
                        my >= m_act[1] && my < m_act[1] + m_act[3];
                hs = s_valid && !m_pend;
                if (bnd && m_pend) begin
                    m_act  = m_shd;
                    m_pend = 0;
                end
                if (hs) begin
                    m_shd  = '{s_cx, s_cy, s_cw, s_ch};
                    m_pend = 1;
                end
                if (m_run) m_pos = (m_pos + 1) % TOTAL;
                if (!m_run || bnd) m_run = s_en;
            end
            fs_e = m_run && (m_pos == TOTAL - 1);
            de_e = h2_run && h2_x < HA && h2_y < VA;
            hs_e = !(h2_run && h2_x >= HA && h2_x < HA + HB / 2);
            vs_e = !(h2_run && h2_y >= VA && h2_y < VA + VB / 2);
            check("frame_start", 32'(frame_start), 32'(fs_e));
            check("cfg_ready",   32'(cfg_ready),   32'(!m_pend));
            check("ram_en",      32'(ram_en),      32'(m_ren));
            check("ram_addr",    32'(ram_addr),    32'(m_addr));
            check("sel_image",   32'(sel_image),   32'(m_sel));
            check("de",          32'(de),          32'(de_e));
            check("hsync",       32'(hsync),       32'(hs_e));
            check("vsync",       32'(vsync),       32'(vs_e));
            check("pix_x",       32'(pix_x),       32'(h2_x));
            check("pix_y",       32'(pix_y),       32'(h2_y));
        end
    end

    task automatic wait_fs(input int limit);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < limit);
        if (!frame_start) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_frame_start: got 0 pulses in %0d cycles, required 1", limit);
        end
    endtask

    task automatic measure(input int n, output int ren, output int de_c, output int hlow,
                           output int fs, output int fs_at, output int last_addr,
                           output int sel_c, output int first_ready);
        ren = 0; de_c = 0; hlow = 0; fs = 0; fs_at = -1; last_addr = -1; sel_c = 0;
        first_ready = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) first_ready = int'(cfg_ready);
            if (ram_en) begin
                ren++;
                last_addr = int'(ram_addr);
            end
            if (de) de_c++;
            if (!hsync) hlow++;
            if (sel_image) sel_c++;
            if (frame_start) begin
                fs++;
                fs_at = i;
            end
        end
    endtask

    task automatic offer(input int x, input int y, input int w, input int h);
        cfg_valid = 1'b1;
        cfg_x = 11'(x);
        cfg_y = 11'(y);
        cfg_w = 8'(w);
        cfg_h = 8'(h);
    endtask

    initial begin : stimulus
        int ren, de_c, hlow, fs, fs_at, last_addr, sel_c, first_ready;

        repeat (3) @(negedge clk);
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset_hsync", 32'(hsync), 32'd1);
        check("reset_de", 32'(de), 32'd0);
        check("reset_ram_addr", 32'(ram_addr), 32'd0);

        // 5x4 window at the origin, taken before the first frame runs
        rst = 1'b0;
        enable = 1'b1;
        offer(0, 0, 5, 4);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("cfg_ready_drop", 32'(cfg_ready), 32'd0);
        wait_fs(TOTAL + 4);
        measure(TOTAL, ren, de_c, hlow, fs, fs_at, last_addr, sel_c, first_ready);
        check("f1_ready_return", 32'(first_ready), 32'd1);
        check("f1_ram_en_count", 32'(ren), 32'd20);
        check("f1_last_addr", 32'(last_addr), 32'd19);
        check("f1_sel_count", 32'(sel_c), 32'd20);
        check("f1_de_count", 32'(de_c), 32'd240);
        check("f1_hsync_low", 32'(hlow), 32'd48);
        check("f1_period", 32'(fs_at), 32'(TOTAL));

        // Handshake on the boundary cycle, then a second offer while busy
        offer(17, 2, 8, 3);
        @(negedge clk);
        check("busy_ready", 32'(cfg_ready), 32'd0);
        offer(0, 0, 50, 50);
        repeat (3) @(negedge clk);
        cfg_valid = 1'b0;
        wait_fs(TOTAL + 4);
        measure(TOTAL, ren, de_c, hlow, fs, fs_at, last_addr, sel_c, first_ready);
        check("clip_ready_return", 32'(first_ready), 32'd1);
        check("clip_ram_en_count", 32'(ren), 32'd9);
        check("clip_last_addr", 32'(last_addr), 32'd8);

        // Drop enable mid-frame: the frame finishes, then everything idles
        repeat (TOTAL / 2) @(negedge clk);
        enable = 1'b0;
        measure(2 * TOTAL, ren, de_c, hlow, fs, fs_at, last_addr, sel_c, first_ready);
        check("drain_frame_starts", 32'(fs), 32'd1);
        measure(TOTAL, ren, de_c, hlow, fs, fs_at, last_addr, sel_c, first_ready);
        check("off_de_count", 32'(de_c), 32'd0);
        check("off_ram_en_count", 32'(ren), 32'd0);
        check("off_hsync_low", 32'(hlow), 32'd0);
        check("off_vsync", 32'(vsync), 32'd1);

        // Brief enable dip inside a frame must not interrupt the raster
        enable = 1'b1;
        wait_fs(TOTAL + 4);
        repeat (100) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        measure(2 * TOTAL, ren, de_c, hlow, fs, fs_at, last_addr, sel_c, first_ready);
        check("dip_frame_starts", 32'(fs), 32'd2);

        // Reset mid-line with a config still pending
        offer(0, 0, 10, 10);
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_de", 32'(de), 32'd0);
        check("rst_mid_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_mid_cfg_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        wait_fs(TOTAL + 4);
        measure(TOTAL, ren, de_c, hlow, fs, fs_at, last_addr, sel_c, first_ready);
        check("rst_discard_ram_en", 32'(ren), 32'd0);

        // Randomised run against the reference model
        for (int c = 0; c < 25000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 499) == 0) enable = !enable;
            cfg_valid = ($urandom_range(0, 39) == 0);
            cfg_x = 11'($urandom_range(0, 26));
            if ($urandom_range(0, 15) == 0) cfg_x = 11'($urandom_range(2000, 2047));
            cfg_y = 11'($urandom_range(0, 15));
            cfg_w = 8'($urandom_range(0, 14));
            if ($urandom_range(0, 15) == 0) cfg_w = 8'($urandom_range(200, 255));
            cfg_h = 8'($urandom_range(0, 10));
        end
        rst = 1'b0;
        cfg_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/video_overlay_ctrl.md
VIDEO_OVERLAY_CTRL -- requirements
Module: video_overlay_ctrl

Interface
REQ-001 SHALL have parameters: H_ACTIVE, default 1366, visible pixels per line.
REQ-002 SHALL have H_BLANK, default 50, blanking pixels per line.
REQ-003 SHALL have V_ACTIVE, default 768, visible lines; and V_BLANK, default 12, blanking lines.
REQ-004 SHALL have ADDR_W, default 14, image-RAM address width.
REQ-005 SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  dot clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have these ports:
- enable  in  1  run request; sampled only at frame boundary.
- cfg_valid  in  1  overlay config offered.
- cfg_ready  out  1  config slot free.
- cfg_x, cfg_y  in  11 each  overlay top-left pixel.
- cfg_w, cfg_h  in  8 each  overlay width and height; 0 disables the overlay.
- ram_en  out  1  image-RAM read strobe.
- ram_addr  out  ADDR_W  image-RAM read address.
- hsync, vsync  out  1 each  active-low syncs.
- de  out  1  data enable.
- sel_image  out  1  pixel mux select: use RAM data this cycle.
- pix_x, pix_y  out  11 each  coordinates of the presented pixel.
- frame_start  out  1  one-cycle pulse at frame boundary.

Function
REQ-007 SHALL keep internal counters x in 0..H_ACTIVE+H_BLANK-1 and y in 0..V_ACTIVE+V_BLANK-1.
REQ-008 x SHALL wrap to 0 after its maximum; y SHALL increment only when x wraps, and SHALL wrap to 0 after its maximum.
REQ-009 The frame boundary SHALL be the cycle where x and y are both at their maximum; frame_start SHALL pulse on that cycle (latency 0).
REQ-010 SHALL implement FSM states OFF, RUN and DRAIN:
- OFF->RUN at reset release when enable=1.
- RUN->DRAIN when enable=0.
- DRAIN->OFF at the frame boundary.
- DRAIN->RUN if enable=1 again before the frame boundary.
REQ-011 In OFF, counters SHALL hold at 0 and outputs SHALL be: hsync=1, vsync=1, de=0, ram_en=0, sel_image=0.
REQ-012 Timing outputs (de, hsync, vsync, pix_x, pix_y, sel_image) SHALL appear 2 cycles after the counter values that produced them.
REQ-013 de SHALL be 1 iff x<H_ACTIVE and y<V_ACTIVE.
REQ-014 hsync SHALL be 0 iff H_ACTIVE <= x < H_ACTIVE+H_BLANK/2.
REQ-015 vsync SHALL be 0 iff V_ACTIVE <= y < V_ACTIVE+V_BLANK/2.
REQ-016 The overlay window SHALL be cfg_x <= x < cfg_x+cfg_w and cfg_y <= y < cfg_y+cfg_h.
- Bounds SHALL be computed at 12 bits, with no wrap.
- The window SHALL be clipped to the active area.
REQ-017 ram_en SHALL be registered 1 cycle after the counters and SHALL be 1 iff the counters are inside the active window.
REQ-018 sel_image SHALL equal ram_en delayed by 1 cycle, matching a 1-cycle RAM.
REQ-019 ram_addr SHALL increment by 1 after each ram_en cycle, wrap at 2^ADDR_W, and reset to 0 at each frame boundary.
REQ-020 On cfg_valid && cfg_ready, the config SHALL be captured into a shadow register and cfg_ready SHALL drop on the next cycle.
REQ-021 The shadow config SHALL become active at the next frame boundary, and cfg_ready SHALL return to 1 on the cycle after that boundary.
REQ-022 A handshake coinciding with a frame boundary SHALL be applied at the following boundary, never mid-frame.
REQ-023 The active config SHALL never change except at a frame boundary.

Reset
REQ-024 On rst=1, the FSM SHALL go to OFF and counters, ram_addr and pipeline registers SHALL go to 0.
REQ-025 On rst=1: hsync=vsync=1, de=ram_en=sel_image=frame_start=0, cfg_ready=1.
REQ-026 On rst=1, the active and shadow config SHALL clear to all-zero, disabling the overlay.
REQ-027 Reset asserted mid-frame SHALL take effect on the next edge and discard any pending config.

Structure
REQ-028 Default timing constants and the FSM state encoding SHALL live in the shared package video_pkg.
REQ-029 The raster counters, sync and de generation SHALL be the sub-module video_raster_cnt; window, config and RAM scheduling SHALL stay in the top.

Verification
REQ-030 Reset, then enable=1 -> frame_start every 1416*780 cycles; each line has 1366 de cycles and a hsync-low run of 25 cycles.
REQ-031 Config x=0,y=0,w=100,h=100 -> 10000 ram_en pulses per frame, ram_addr 0..9999; sel_image is high exactly at pix_x<100, pix_y<100.
REQ-032 Config x=1300,w=100 -> only 66 ram_en per line (clipped); no ram_en in blanking.
REQ-033 Second cfg_valid while cfg_ready=0 -> ignored; the first config takes effect only at the next frame_start.
REQ-034 enable=0 mid-frame -> frame completes, then OFF with outputs idle; enable=1 before the boundary -> no interruption.
REQ-035 rst pulse mid-line -> next cycle de=0, ram_addr=0, cfg_ready=1.
